// File: rtl/operand_sel_reg_pkg.sv
// Shared constants for the EX-stage operand selector: forwarding select codes,
// default bus width and the saturating error-counter helper.
package operand_sel_reg_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_IMM   = 2'd3
  } fwd_sel_e;

  localparam int DEFAULT_BUS_SIZE = 32;
  localparam int ERR_CNT_W        = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/operand_sel_reg_mux_nto1.sv
// Combinational N-to-1 bus selector; out-of-range selects return input 0 and raise oor.
module mux_nto1 #(
  parameter int bus_size = 32,
  parameter int N_INPUTS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [N_INPUTS*bus_size-1:0] in_bus,
  input  logic [SEL_W-1:0]             sel,
  output logic [bus_size-1:0]          out,
  output logic                         oor
);

  localparam logic [SEL_W:0] LP_N = (SEL_W+1)'(N_INPUTS);

  always_comb begin
    oor = ({1'b0, sel} >= LP_N);
    out = in_bus[0 +: bus_size];
    for (int i = 1; i < N_INPUTS; i++) begin
      if (sel == i[SEL_W-1:0]) out = in_bus[i*bus_size +: bus_size];
    end
  end

endmodule

// File: rtl/operand_sel_reg.sv
// Registered N-to-1 operand selector with stall/flush and out-of-range flag.
// Optional saturating error counter on port err_cnt when OPSEL_ERR_CNT_EN is defined.
module operand_sel_reg
  import operand_sel_reg_pkg::*;
#(
  parameter int bus_size = DEFAULT_BUS_SIZE,
  parameter int N_INPUTS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_INPUTS*bus_size-1:0] in_bus,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         in_valid,
  input  logic                         stall,
  input  logic                         flush,
  output logic [bus_size-1:0]          out,
  output logic                         out_valid,
  output logic                         sel_err
`ifdef OPSEL_ERR_CNT_EN
  ,output logic [ERR_CNT_W-1:0]        err_cnt
`endif
);

  if ((2**SEL_W) < N_INPUTS || N_INPUTS < 2 || N_INPUTS > 16) begin : g_param_err
    $error("operand_sel_reg: need 2 <= N_INPUTS <= 16 and 2**SEL_W >= N_INPUTS");
  end

  logic [bus_size-1:0] w_mux_out;
  logic                w_oor;
  logic                w_load;
  logic [bus_size-1:0] r_out;
  logic                r_valid;
  logic                r_err;

  mux_nto1 #(
    .bus_size (bus_size),
    .N_INPUTS (N_INPUTS),
    .SEL_W    (SEL_W)
  ) u_mux (
    .in_bus (in_bus),
    .sel    (sel),
    .out    (w_mux_out),
    .oor    (w_oor)
  );

  assign w_load = !flush && !stall;

  // Priority: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_out   <= w_mux_out;
      r_valid <= in_valid;
      r_err   <= w_oor & in_valid;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign sel_err   = r_err;

`ifdef OPSEL_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Counts edges that load a new error; flush and stall leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_load && w_oor && in_valid) begin
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_operand_sel_reg.sv
// Directed, table-driven bench for operand_sel_reg: a 4-input instance for the main
// function and a 3-input instance for the out-of-range select path.
module tb_operand_sel_reg;
  import operand_sel_reg_pkg::*;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        stall;
    logic        vld;
    logic [1:0]  sel;
    logic [127:0] bus;
    logic [31:0] exp_out;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, stall, flush, in_valid;
  logic [1:0]   sel;
  logic [127:0] bus4;
  logic [95:0]  bus3;
  logic [31:0]  out4, out3;
  logic         ov4, ov3, err4, err3;
`ifdef OPSEL_ERR_CNT_EN
  logic [7:0]   cnt4, cnt3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign bus3 = bus4[95:0];

  operand_sel_reg #(.bus_size(32), .N_INPUTS(4), .SEL_W(2)) dut4 (
    .clk(clk), .reset(reset), .in_bus(bus4), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out4), .out_valid(ov4), .sel_err(err4)
`ifdef OPSEL_ERR_CNT_EN
    , .err_cnt(cnt4)
`endif
  );

  operand_sel_reg #(.bus_size(32), .N_INPUTS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .in_bus(bus3), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out3), .out_valid(ov3), .sel_err(err3)
`ifdef OPSEL_ERR_CNT_EN
    , .err_cnt(cnt3)
`endif
  );

  localparam logic [127:0] STD = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] ALT = {32'hA4, 32'hA3, 32'hA2, 32'hA1};

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic v,
                              input logic [1:0] sl, input logic [127:0] b,
                              input logic [31:0] eo, input logic ev, input logic ee);
    vec_t t;
    t.rst = r; t.flush = f; t.stall = s; t.vld = v; t.sel = sl; t.bus = b;
    t.exp_out = eo; t.exp_valid = ev; t.exp_err = ee;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic s, input logic v,
                       input logic [1:0] sl, input logic [127:0] b);
    @(negedge clk);
    reset = r; flush = f; stall = s; in_valid = v; sel = sl; bus4 = b;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; sel = '0; bus4 = '0;

    //            rst f s v  sel        bus   out    ov err
    tbl.push_back(mk(1, 0, 0, 1, FWD_EXMEM, STD, 32'h0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 1, FWD_EXMEM, STD, 32'h0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_RF,    STD, 32'h11, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_EXMEM, STD, 32'h22, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_MEMWB, STD, 32'h33, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_IMM,   STD, 32'h44, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_MEMWB, STD, 32'h33, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, FWD_EXMEM, ALT, 32'h33, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, FWD_EXMEM, ALT, 32'h33, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, FWD_EXMEM, ALT, 32'h33, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_EXMEM, STD, 32'h22, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_IMM,   STD, 32'h44, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, FWD_RF,    STD, 32'h0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_EXMEM, STD, 32'h22, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, FWD_MEMWB, STD, 32'h33, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_MEMWB, ALT, 32'hA3, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, FWD_RF,    STD, 32'h0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_IMM,   STD, 32'h44, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, FWD_RF,    STD, 32'h44, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, FWD_RF,    STD, 32'h0,  0, 0));
    tbl.push_back(mk(0, 0, 1, 1, FWD_MEMWB, STD, 32'h0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 1, FWD_EXMEM, STD, 32'h22, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].vld, tbl[i].sel, tbl[i].bus);
      check($sformatf("v%0d out", i),       out4,        tbl[i].exp_out);
      check($sformatf("v%0d out_valid", i), 32'(ov4),    32'(tbl[i].exp_valid));
      check($sformatf("v%0d sel_err", i),   32'(err4),   32'(tbl[i].exp_err));
`ifdef OPSEL_ERR_CNT_EN
      check($sformatf("v%0d err_cnt4", i),  32'(cnt4),   32'h0);
`endif
    end

    // Out-of-range select on the 3-input instance
    drive(1, 0, 0, 0, 2'd0, STD);
    check("n3 reset out", out3, 32'h0);
    check("n3 reset err", 32'(err3), 32'h0);
`ifdef OPSEL_ERR_CNT_EN
    check("n3 reset cnt", 32'(cnt3), 32'h0);
`endif
    drive(0, 0, 0, 1, 2'd3, STD);
    check("n3 oor out", out3, 32'h11);
    check("n3 oor valid", 32'(ov3), 32'h1);
    check("n3 oor err", 32'(err3), 32'h1);
    check("n4 sel3 no err", 32'(err4), 32'h0);
    drive(0, 0, 0, 1, 2'd0, STD);
    check("n3 err pulse clears", 32'(err3), 32'h0);
    drive(0, 0, 0, 0, 2'd3, ALT);
    check("n3 invalid oor out", out3, 32'hA1);
    check("n3 invalid oor valid", 32'(ov3), 32'h0);
    check("n3 invalid oor err", 32'(err3), 32'h0);
    drive(0, 0, 0, 1, 2'd3, STD);
    check("n3 oor err again", 32'(err3), 32'h1);
    drive(0, 0, 1, 1, 2'd0, STD);
    check("n3 err held by stall", 32'(err3), 32'h1);
    drive(0, 1, 0, 1, 2'd3, STD);
    check("n3 flush clears err", 32'(err3), 32'h0);
    check("n3 flush clears valid", 32'(ov3), 32'h0);
`ifdef OPSEL_ERR_CNT_EN
    check("n3 cnt after 2 errs", 32'(cnt3), 32'h2);
`endif
    drive(0, 0, 0, 1, 2'd2, STD);
    check("n3 in-range out", out3, 32'h33);
    check("n3 in-range err", 32'(err3), 32'h0);

`ifdef OPSEL_ERR_CNT_EN
    drive(1, 0, 0, 0, 2'd0, STD);
    check("n3 cnt reset", 32'(cnt3), 32'h0);
    for (int k = 1; k <= 300; k++) begin
      drive(0, 0, 0, 1, 2'd3, STD);
      if (k == 1)   check("cnt after 1",   32'(cnt3), 32'h1);
      if (k == 254) check("cnt after 254", 32'(cnt3), 32'hFE);
      if (k == 255) check("cnt after 255", 32'(cnt3), 32'hFF);
    end
    check("cnt after 300", 32'(cnt3), 32'hFF);
    drive(0, 1, 1, 1, 2'd3, STD);
    check("cnt kept by flush", 32'(cnt3), 32'hFF);
    drive(1, 0, 0, 1, 2'd3, STD);
    check("cnt cleared by reset", 32'(cnt3), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
